// File: rtl/seq_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_lock_pkg
// Description : Shared state encoding for the sequence lock detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_lock_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_HUNT     = 2'd0,
        ST_CONFIRM  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_FLYWHEEL = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_match.sv
`default_nettype none
// ============================================================================
// Module      : seq_match
// Description : Serial shift register with fill tracking; flags when the
//               post-shift contents equal the sync pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic x_valid,
    output logic match
);

    localparam int c_FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]    r_shift;
    logic [c_FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]    w_shift_nxt;
    logic [c_FILL_W-1:0] w_fill_nxt;

    always_comb begin
        w_shift_nxt = {r_shift[PAT_W-2:0], x};
        w_fill_nxt  = (r_fill == c_FILL_W'(PAT_W)) ? r_fill : r_fill + c_FILL_W'(1);
    end

    // Match looks at the register as it will be after this bit lands, so the
    // decision and the shift happen on the same edge.
    assign match = x_valid && (w_fill_nxt == c_FILL_W'(PAT_W)) && (w_shift_nxt == PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_fill  <= '0;
        end else if (x_valid) begin
            r_shift <= w_shift_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_lock_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_lock_detector
// Description : Frame sync detector: hunts a serial pattern, confirms it at
//               the frame period, then tracks lock with flywheel tolerance.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_lock_detector
    import seq_lock_pkg::*;
#(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PATTERN   = 4'b1011,
    parameter int               FRAME_LEN = 8,
    parameter int               LOCK_CNT  = 2,
    parameter int               LOSS_CNT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x,
    input  logic                 x_valid,
    input  logic                 resync,
    output logic                 y,
    output logic                 lck,
    output logic [c_STATE_W-1:0] state,
    output logic                 frm
);

    localparam int c_BIT_W  = $clog2(FRAME_LEN + 1);
    localparam int c_CONF_W = $clog2(LOCK_CNT + 1);
    localparam int c_MISS_W = $clog2(LOSS_CNT + 1);

    state_t              r_state;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_CONF_W-1:0] r_conf_cnt;
    logic [c_MISS_W-1:0] r_miss_cnt;
    logic                r_y;
    logic                r_frm;
    logic                r_lck;

    state_t              w_state_nxt;
    logic [c_BIT_W-1:0]  w_bit_nxt;
    logic [c_CONF_W-1:0] w_conf_nxt;
    logic [c_MISS_W-1:0] w_miss_nxt;
    logic                w_y_nxt;
    logic                w_frm_nxt;
    logic                w_lck_nxt;

    logic                w_match;
    logic [c_BIT_W-1:0]  w_bit_inc;
    logic [c_CONF_W-1:0] w_conf_inc;
    logic [c_MISS_W-1:0] w_miss_inc;
    logic                w_boundary;

    seq_match #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .x_valid (x_valid),
        .match   (w_match)
    );

    assign w_bit_inc  = r_bit_cnt + c_BIT_W'(1);
    assign w_conf_inc = r_conf_cnt + c_CONF_W'(1);
    assign w_miss_inc = r_miss_cnt + c_MISS_W'(1);
    assign w_boundary = x_valid && (w_bit_inc == c_BIT_W'(FRAME_LEN));

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_conf_nxt  = r_conf_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_y_nxt     = 1'b0;
        w_frm_nxt   = 1'b0;

        if (resync) begin
            w_state_nxt = ST_HUNT;
            w_bit_nxt   = '0;
            w_conf_nxt  = '0;
            w_miss_nxt  = '0;
        end else if (x_valid) begin
            w_bit_nxt = w_bit_inc;
            if (r_state == ST_HUNT) begin
                // Any position is acceptable while hunting; the match anchors frame timing.
                if (w_match) begin
                    w_state_nxt = ST_CONFIRM;
                    w_bit_nxt   = '0;
                    w_conf_nxt  = '0;
                    w_y_nxt     = 1'b1;
                end
            end else if (w_boundary) begin
                w_bit_nxt = '0;
                w_frm_nxt = 1'b1;
                w_y_nxt   = w_match;
                case (r_state)
                    ST_CONFIRM: begin
                        if (w_match) begin
                            w_conf_nxt = w_conf_inc;
                            if (w_conf_inc == c_CONF_W'(LOCK_CNT)) begin
                                w_state_nxt = ST_LOCKED;
                            end
                        end else begin
                            w_state_nxt = ST_HUNT;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_match) begin
                            if (LOSS_CNT <= 1) begin
                                w_state_nxt = ST_HUNT;
                                w_miss_nxt  = '0;
                            end else begin
                                w_state_nxt = ST_FLYWHEEL;
                                w_miss_nxt  = c_MISS_W'(1);
                            end
                        end
                    end
                    ST_FLYWHEEL: begin
                        if (w_match) begin
                            w_state_nxt = ST_LOCKED;
                            w_miss_nxt  = '0;
                        end else if (w_miss_inc == c_MISS_W'(LOSS_CNT)) begin
                            w_state_nxt = ST_HUNT;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt  = w_miss_inc;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_HUNT;
                    end
                endcase
            end
        end

        w_lck_nxt = (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_FLYWHEEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_bit_cnt  <= '0;
            r_conf_cnt <= '0;
            r_miss_cnt <= '0;
            r_y        <= 1'b0;
            r_frm      <= 1'b0;
            r_lck      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_conf_cnt <= w_conf_nxt;
            r_miss_cnt <= w_miss_nxt;
            r_y        <= w_y_nxt;
            r_frm      <= w_frm_nxt;
            r_lck      <= w_lck_nxt;
        end
    end

    assign y     = r_y;
    assign frm   = r_frm;
    assign lck   = r_lck;
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_lock_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_lock_detector
// Description : Self-checking bench: directed lock/flywheel/resync/reset
//               scenarios plus randomized frames against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_lock_detector;

    localparam int               PAT_W     = 4;
    localparam logic [PAT_W-1:0] PATTERN   = 4'b1011;
    localparam int               FRAME_LEN = 8;
    localparam int               LOCK_CNT  = 2;
    localparam int               LOSS_CNT  = 2;
    localparam logic [PAT_W-1:0] PATTERN_Z = 4'b0001;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       x       = 1'b0;
    logic       x_valid = 1'b0;
    logic       resync  = 1'b0;
    logic       y, lck, frm;
    logic [1:0] state;
    logic       y_z, lck_z, frm_z;
    logic [1:0] state_z;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_lock_detector #(
        .PAT_W(PAT_W), .PATTERN(PATTERN), .FRAME_LEN(FRAME_LEN),
        .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .resync(resync),
        .y(y), .lck(lck), .state(state), .frm(frm)
    );

    // Pattern with leading zeros: only the fill count keeps it from firing early after reset.
    seq_lock_detector #(
        .PAT_W(PAT_W), .PATTERN(PATTERN_Z), .FRAME_LEN(FRAME_LEN),
        .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut_z (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .resync(resync),
        .y(y_z), .lck(lck_z), .state(state_z), .frm(frm_z)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit hist[$];
    int m_st    = 0;
    int m_since = 0;
    int m_good  = 0;
    int m_miss  = 0;
    bit e_y     = 0;
    bit e_frm   = 0;

    function automatic bit hist_match();
        logic [PAT_W-1:0] p;
        p = PATTERN;
        if (hist.size() != PAT_W) return 1'b0;
        for (int i = 0; i < PAT_W; i++)
            if (hist[i] != p[PAT_W-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_st = 0; m_since = 0; m_good = 0; m_miss = 0;
        e_y = 0; e_frm = 0;
    endtask

    task automatic model_step();
        bit m;
        m = 1'b0;
        e_y = 1'b0;
        e_frm = 1'b0;
        if (x_valid) begin
            hist.push_back(x);
            if (hist.size() > PAT_W) hist.delete(0);
            m = hist_match();
        end
        if (resync) begin
            m_st = 0; m_since = 0; m_good = 0; m_miss = 0;
        end else if (x_valid) begin
            m_since++;
            if (m_st == 0) begin
                if (m) begin
                    m_st = 1; m_since = 0; m_good = 0; e_y = 1'b1;
                end
            end else if (m_since == FRAME_LEN) begin
                m_since = 0;
                e_frm = 1'b1;
                e_y = m;
                if (m_st == 1) begin
                    if (m) begin
                        m_good++;
                        if (m_good >= LOCK_CNT) m_st = 2;
                    end else m_st = 0;
                end else if (m_st == 2) begin
                    if (!m) begin
                        m_miss = 1;
                        m_st = (m_miss >= LOSS_CNT) ? 0 : 3;
                    end
                end else begin
                    if (m) begin
                        m_st = 2; m_miss = 0;
                    end else begin
                        m_miss++;
                        if (m_miss >= LOSS_CNT) begin m_st = 0; m_miss = 0; end
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("y", {31'd0, y}, {31'd0, e_y});
            chk("frm", {31'd0, frm}, {31'd0, e_frm});
            chk("state", {30'd0, state}, 32'(m_st));
            chk("lck", {31'd0, lck}, (m_st >= 2) ? 32'd1 : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic bit_in(input bit b, input bit v);
        x = b;
        x_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_in(input logic [FRAME_LEN-1:0] f);
        for (int i = FRAME_LEN - 1; i >= 0; i--) bit_in(f[i], 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        x_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [FRAME_LEN-1:0] fr;
        int kind;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", {31'd0, y}, 32'd0);
        chk("rst_frm", {31'd0, frm}, 32'd0);
        chk("rst_lck", {31'd0, lck}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        rst_n = 1'b1;

        // Overlapping pattern: accepted in HUNT, ignored off-boundary in CONFIRM
        bit_in(1, 1); bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
        chk("ovl_y_bit4", {31'd0, y}, 32'd1);
        chk("ovl_state_bit4", {30'd0, state}, 32'd1);
        bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
        chk("ovl_y_bit7", {31'd0, y}, 32'd0);
        chk("ovl_state_bit7", {30'd0, state}, 32'd1);

        // Acquire lock on 0000_1011 frames
        do_reset();
        frame_in(8'h0B);
        chk("acq_y8", {31'd0, y}, 32'd1);
        chk("acq_frm8", {31'd0, frm}, 32'd0);
        chk("acq_state8", {30'd0, state}, 32'd1);
        frame_in(8'h0B);
        chk("acq_y16", {31'd0, y}, 32'd1);
        chk("acq_frm16", {31'd0, frm}, 32'd1);
        chk("acq_lck16", {31'd0, lck}, 32'd0);
        frame_in(8'h0B);
        chk("acq_y24", {31'd0, y}, 32'd1);
        chk("acq_frm24", {31'd0, frm}, 32'd1);
        chk("acq_lck24", {31'd0, lck}, 32'd1);
        chk("acq_state24", {30'd0, state}, 32'd2);

        // Single corrupted frame: flywheel, then recover
        frame_in(8'h0A);
        chk("fly_state", {30'd0, state}, 32'd3);
        chk("fly_lck", {31'd0, lck}, 32'd1);
        chk("fly_y", {31'd0, y}, 32'd0);
        frame_in(8'h0B);
        chk("rec_state", {30'd0, state}, 32'd2);
        chk("rec_y", {31'd0, y}, 32'd1);

        // Three invalid cycles mid-frame delay the boundary
        bit_in(0, 1); bit_in(0, 1); bit_in(0, 1); bit_in(0, 1);
        for (int i = 0; i < 3; i++) begin
            bit_in(1, 0);
            chk("gap_frm", {31'd0, frm}, 32'd0);
        end
        bit_in(1, 1); chk("gap_frm_b5", {31'd0, frm}, 32'd0);
        bit_in(0, 1); chk("gap_frm_b6", {31'd0, frm}, 32'd0);
        bit_in(1, 1); chk("gap_frm_b7", {31'd0, frm}, 32'd0);
        bit_in(1, 1);
        chk("gap_frm_b8", {31'd0, frm}, 32'd1);
        chk("gap_y_b8", {31'd0, y}, 32'd1);
        chk("gap_state", {30'd0, state}, 32'd2);

        // Two corrupted frames drop lock
        frame_in(8'h0A);
        chk("loss1_state", {30'd0, state}, 32'd3);
        frame_in(8'h0A);
        chk("loss2_state", {30'd0, state}, 32'd0);
        chk("loss2_lck", {31'd0, lck}, 32'd0);

        // Relock then resync
        repeat (3) frame_in(8'h0B);
        chk("relock_lck", {31'd0, lck}, 32'd1);
        resync = 1'b1;
        bit_in(0, 1);
        resync = 1'b0;
        chk("resync_state", {30'd0, state}, 32'd0);
        chk("resync_lck", {31'd0, lck}, 32'd0);
        chk("resync_y", {31'd0, y}, 32'd0);

        // Async reset mid-frame while locked
        repeat (3) frame_in(8'h0B);
        chk("pre_rst_lck", {31'd0, lck}, 32'd1);
        bit_in(0, 1); bit_in(0, 1); bit_in(0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_y", {31'd0, y}, 32'd0);
        chk("arst_frm", {31'd0, frm}, 32'd0);
        chk("arst_lck", {31'd0, lck}, 32'd0);
        chk("arst_state", {30'd0, state}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fresh fill after reset
        bit_in(1, 1);
        chk("fill_z_y1", {31'd0, y_z}, 32'd0);
        bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
        chk("fill_y4", {31'd0, y}, 32'd1);
        do_reset();
        bit_in(1, 1);
        chk("fill_z_y1b", {31'd0, y_z}, 32'd0);
        bit_in(0, 1); bit_in(0, 1); bit_in(0, 1); bit_in(1, 1);
        chk("fill_z_y5", {31'd0, y_z}, 32'd1);

        // Randomized frames: corruptions, slips, gaps and occasional resync
        do_reset();
        for (int f = 0; f < 320; f++) begin
            kind = $urandom_range(0, 99);
            fr = 8'h0B;
            if (kind < 12) fr = fr ^ 8'(1 << $urandom_range(0, 7));
            else if (kind < 20) fr = 8'($urandom);
            if (kind >= 95) begin
                for (int k = 0; k < $urandom_range(1, 3); k++) bit_in(1'($urandom_range(0, 1)), 1'b1);
            end
            for (int i = FRAME_LEN - 1; i >= 0; i--) begin
                if ($urandom_range(0, 9) == 0) bit_in(1'($urandom_range(0, 1)), 1'b0);
                resync = ($urandom_range(0, 249) == 0);
                bit_in(fr[i], 1'b1);
                resync = 1'b0;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_lock_detector.md
SEQ_LOCK_DETECTOR -- requirements
Module: seq_lock_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 4, sync-pattern width in bits (2..32).
REQ-002 SHALL have parameter PATTERN, default 4'b1011, sync pattern; the MSB is the oldest bit received.
REQ-003 SHALL have parameter FRAME_LEN, default 8, bits from one pattern end to the next (>= PAT_W).
REQ-004 SHALL have parameter LOCK_CNT, default 2, consecutive on-time matches after the first, needed to lock (>= 1).
REQ-005 SHALL have parameter LOSS_CNT, default 2, consecutive on-time misses that drop lock (>= 1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port x, input, 1 bit: serial data bit.
REQ-009 SHALL have port x_valid, input, 1 bit: qualifies x; when low, the bit is ignored and no counter advances.
REQ-010 SHALL have port resync, input, 1 bit: synchronous force to HUNT.
REQ-011 SHALL have port y, output, 1 bit: one-cycle pulse on an accepted pattern match.
REQ-012 SHALL have port lck, output, 1 bit: high while in LOCKED or FLYWHEEL.
REQ-013 SHALL have port state, output, 2 bits: current FSM state.
REQ-014 SHALL have port frm, output, 1 bit: one-cycle pulse at each expected frame boundary.

Function
REQ-015 SHALL shift x into a PAT_W-bit register at the LSB on each clk edge with x_valid=1.
- A fill counter saturates at PAT_W.
- Match is true only when the fill count is PAT_W and the post-shift register equals PATTERN.
REQ-016 SHALL keep a bit counter, width $clog2(FRAME_LEN+1).
- Cleared to 0 on an accepted match.
- Incremented on each valid bit otherwise.
- A boundary occurs on the valid bit that brings the counter to FRAME_LEN.
REQ-017 SHALL implement four states: HUNT=0, CONFIRM=1, LOCKED=2, FLYWHEEL=3.
REQ-018 HUNT: any match -> CONFIRM; bit counter cleared; confirm count cleared.
REQ-019 CONFIRM: matches between boundaries are ignored.
- Boundary with match: confirm count +1; at LOCK_CNT -> LOCKED, else stay.
- Boundary with miss: -> HUNT.
REQ-020 LOCKED: boundary with match -> stay; boundary with miss -> FLYWHEEL, miss count = 1.
REQ-021 FLYWHEEL: boundary with match -> LOCKED, miss count = 0.
- Boundary with miss: miss count +1; at LOSS_CNT -> HUNT.
- Otherwise stay.
REQ-022 In every non-HUNT state, SHALL clear the bit counter at each boundary, hit or miss, so frame timing is kept.
REQ-023 SHALL assert y for the cycle after the accepting edge.
- Accepting edges: any match in HUNT, or a boundary match in any other state.
- Latency is one clk edge.
REQ-024 SHALL assert frm for the cycle after each boundary edge, in non-HUNT states only.
REQ-025 lck, state, y and frm SHALL be registered outputs.
REQ-026 resync=1 SHALL take priority over all transitions.
- Next state HUNT; y and frm = 0.
- Counters cleared, except the shift register and fill count, which keep updating.
REQ-027 A pattern overlapping itself SHALL be detected in HUNT; in other states, only the boundary position counts.
REQ-028 x_valid=0 on a would-be boundary cycle SHALL delay the boundary to the next valid bit.

Reset
REQ-029 On rst_n=0, SHALL asynchronously clear the following:
- state=HUNT, y=0, lck=0, frm=0.
- Shift register, fill, bit, confirm and miss counters = 0.
REQ-030 Reset released mid-stream SHALL need PAT_W valid bits before any match is possible.

Structure
REQ-031 SHALL place the state encoding enum and state-width constant in shared package seq_lock_pkg.
REQ-032 SHALL place the shift register, fill counter and comparator in sub-module seq_match (params PAT_W, PATTERN; output match).

Verification
REQ-033 After reset, stream 0000_1011 repeated (defaults), the bench SHALL check:
- y pulses after bit 8.
- frm and y pulse after bits 16 and 24.
- lck=1 after bit 24.
REQ-034 Once locked, corrupt one frame's last bit, then resume; the bench SHALL check:
- state goes to FLYWHEEL with lck held at 1.
- The next good frame returns state to LOCKED.
REQ-035 Once locked, corrupt two consecutive frames; the bench SHALL check that lck=0 and state=HUNT after the second miss boundary.
REQ-036 Input 1011011 in HUNT SHALL produce y after bit 4; in CONFIRM, no y after bit 7.
REQ-037 Once locked, with x_valid low for 3 cycles mid-frame, the boundary and frm SHALL shift by 3 cycles and lock SHALL be kept.
REQ-038 The bench SHALL check both of the following:
- resync pulse while LOCKED -> state=HUNT and lck=0 the next cycle.
- rst_n low mid-frame -> all outputs 0 immediately, without waiting for a clk edge.
